// File: rtl/piso8tx.sv
// piso8tx: 8-bit parallel-in serial-out transmitter, LSB first, valid/ready byte intake.
// Optional even-parity ninth cycle is enabled with `define PISO8_PARITY_EN.
module piso8tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] Pin,
    input  logic       Pvalid,
    output logic       Prdy,
    output logic       Sout,
    output logic       Sen,
    output logic       Spar,
    output logic       Busy,
    output logic       Done
);

    // Handshake: a byte transfers on a rising edge where Pvalid && Prdy; Prdy does not
    // depend on Pvalid, and Pin is only looked at on that edge.

`ifdef PISO8_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t     state;
    logic [7:0] sh;
    logic [2:0] cnt;
    logic       last;
    logic       accept;
`ifdef PISO8_PARITY_EN
    logic       par;
`endif

    // The final cycle of a frame doubles as an intake slot so frames can abut.
    always_comb begin
`ifdef PISO8_PARITY_EN
        last = (state == PAR);
`else
        last = (state == SHIFT) && (cnt == 3'd7);
`endif
        Prdy   = (state == IDLE) || last;
        accept = Pvalid && Prdy;
        Done   = last;
        Busy   = (state != IDLE);
        Sen    = (state == SHIFT);
`ifdef PISO8_PARITY_EN
        Sout   = ((state == SHIFT) && sh[0]) || ((state == PAR) && par);
        Spar   = (state == PAR);
`else
        Sout   = (state == SHIFT) && sh[0];
        Spar   = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sh    <= 8'd0;
            cnt   <= 3'd0;
`ifdef PISO8_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (accept) begin
            state <= SHIFT;
            sh    <= Pin;
            cnt   <= 3'd0;
`ifdef PISO8_PARITY_EN
            par   <= ^Pin;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    sh  <= {1'b0, sh[7:1]};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
`ifdef PISO8_PARITY_EN
                        state <= PAR;
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef PISO8_PARITY_EN
                PAR:     state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso8tx.sv
// tb_piso8tx: randomized self-checking bench for piso8tx against a frame-level model.
// Follows the DUT build: define PISO8_PARITY_EN for both to check the parity variant.
module tb_piso8tx;

`ifdef PISO8_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] Pin = 8'd0;
    logic       Pvalid = 1'b0;
    logic       Prdy, Sout, Sen, Spar, Busy, Done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [5:0] exp_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rx_po = 8'd0;

    piso8tx dut (
        .clk(clk), .rst(rst), .Pin(Pin), .Pvalid(Pvalid),
        .Prdy(Prdy), .Sout(Sout), .Sen(Sen), .Spar(Spar), .Busy(Busy), .Done(Done)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Receiver in serial-load mode while Sen is high, LSB arriving first.
    always @(posedge clk) if (Sen) rx_po <= {Sout, rx_po[7:1]};

    function automatic logic [5:0] obs();
        return {Prdy, Sout, Sen, Spar, Busy, Done};
    endfunction

    // Expected {Prdy,Sout,Sen,Spar,Busy,Done} for cycle j of a frame carrying b.
    function automatic logic [5:0] frame_vec(logic [7:0] b, int j);
        logic data_ph, sout, fin;
        logic [7:0] t;
        t       = b >> j;
        data_ph = (j < 8);
        sout    = data_ph ? t[0] : ^b;
        fin     = (j == FL - 1);
        return {fin, sout, data_ph, ~data_ph, 1'b1, fin};
    endfunction

    localparam logic [5:0] IDLE_VEC = 6'b100000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends tx_q back to back with Pvalid held; random junk on Pin outside the intake slot.
    task automatic run_stream(input string tag);
        int n;
        logic [5:0] e;
        n = tx_q.size();
        exp_q = {};
        for (int f = 0; f < n; f++)
            for (int j = 0; j < FL; j++) exp_q.push_back(frame_vec(tx_q[f], j));
        exp_q.push_back(IDLE_VEC);
        Pin    = tx_q[0];
        Pvalid = 1'b1;
        for (int c = 0; c <= n * FL; c++) begin
            tick();
            if (c < n * FL && (c % FL) == FL - 1 && (c / FL) + 1 < n) begin
                Pin    = tx_q[c / FL + 1];
                Pvalid = 1'b1;
            end else if (c >= n * FL - 1) begin
                Pin    = 8'($urandom);
                Pvalid = 1'b0;
            end else begin
                Pin    = 8'($urandom);
                Pvalid = 1'b1;
            end
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e)
                $display("FAIL %s cycle %0d: {Prdy,Sout,Sen,Spar,Busy,Done} got %b expected %b",
                         tag, c, obs(), e);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        Pin    = 8'hA5;
        Pvalid = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        Pvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs() !== IDLE_VEC) $display("FAIL reset_state: got %b expected %b", obs(), IDLE_VEC);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (obs() !== IDLE_VEC) $display("FAIL reset_hold: got %b expected %b", obs(), IDLE_VEC);
        else n_pass++;
    endtask

    task automatic test_first_a5();
        tx_q = {8'hA5};
        run_stream("first_a5");
    endtask

    task automatic test_loopback();
        tx_q = {8'h3C};
        run_stream("loopback");
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rx_po !== 8'h3C) $display("FAIL loopback_po %0d: got %h expected 3c", k, rx_po);
            else n_pass++;
            tick();
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        tx_q = {8'hFF, 8'h01};
        run_stream("back_to_back");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            tx_q = {};
            for (int k = 0; k < $urandom_range(1, 4); k++) tx_q.push_back(8'($urandom));
            run_stream($sformatf("random%0d", r));
            for (int g = 0; g < $urandom_range(0, 2); g++) tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b      = 8'h81;
        Pin    = b;
        Pvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            Pin    = 8'h12;
            Pvalid = 1'b1;
            if (c == 2) begin
                rst    = 1'b1;
                Pvalid = 1'b1;
            end
            @(negedge clk);
            n_checks++;
            if (obs() !== frame_vec(b, c))
                $display("FAIL reset_mid bit %0d: got %b expected %b", c, obs(), frame_vec(b, c));
            else n_pass++;
        end
        tick();
        rst    = 1'b0;
        Pvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs() !== IDLE_VEC) $display("FAIL reset_mid_abort: got %b expected %b", obs(), IDLE_VEC);
        else n_pass++;
        tick();
        tx_q = {8'h55};
        run_stream("after_reset_55");
    endtask

    initial begin
        test_reset();
        test_first_a5();
        test_loopback();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
